// File: rtl/lii_out_arbiter.sv
// lii_out_arbiter: shares one LII output channel between N kernel streams.
// Round-robin grant, the owner keeps the channel until tlast or MAXBURST
// beats, and every beat is tagged with its source and destination id.
module lii_out_arbiter #(
    parameter  int N        = 4,
    parameter  int PW       = 256,
    parameter  int SRC_BASE = 0,
    parameter  int MAXBURST = 16,
    localparam int GW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            aclk,
    input  logic            arst,
    input  logic [N*PW-1:0] req_tdata,
    input  logic [N-1:0]    req_tvalid,
    output logic [N-1:0]    req_tready,
    input  logic [N-1:0]    req_tlast,
    input  logic [N*8-1:0]  req_dst,
    output logic [PW-1:0]   lii_out_p0_tdata,
    output logic            lii_out_p0_tvalid,
    input  logic            lii_out_p0_tready,
    output logic [7:0]      lii_out_p0_src,
    output logic [7:0]      lii_out_p0_dst,
    output logic [GW-1:0]   grant_id,
    output logic            busy
);

    localparam int CW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          tvalid_q;
    logic [PW-1:0] tdata_q;
    logic [7:0]    src_q, dst_q;

    logic          load, xfer, burst_end;
    logic          own_vld, own_last;
    logic [PW-1:0] own_data;
    logic [7:0]    own_src, own_dst;

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [GW:0]    sum;
    logic [GW-1:0]  pick, rr_next;
    logic           pick_vld;

    // The output register can take a new beat when empty or draining this cycle.
    assign load      = ~tvalid_q | lii_out_p0_tready;
    assign busy      = (state_q == BURST);
    assign grant_id  = grant_q;
    assign xfer      = busy & load & own_vld;
    assign burst_end = xfer & (own_last | (cnt_q == CW'(MAXBURST - 1)));
    assign rr_next   = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;

    assign lii_out_p0_tvalid = tvalid_q;
    assign lii_out_p0_tdata  = tdata_q;
    assign lii_out_p0_src    = src_q;
    assign lii_out_p0_dst    = dst_q;

    // Select the owner's stream fields and steer ready back to the owner only.
    always_comb begin
        own_vld    = 1'b0;
        own_last   = 1'b0;
        own_data   = '0;
        own_src    = '0;
        own_dst    = '0;
        req_tready = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == GW'(i)) begin
                own_vld       = req_tvalid[i];
                own_last      = req_tlast[i];
                own_data      = req_tdata[i*PW +: PW];
                own_dst       = req_dst[i*8 +: 8];
                own_src       = 8'(SRC_BASE + i);
                req_tready[i] = load & busy;
            end
        end
    end

    // Round-robin pick: rotate valids so rr_q sits at bit 0, take the first set bit.
    always_comb begin
        dbl      = {req_tvalid, req_tvalid};
        rot      = dbl[{1'b0, rr_q} +: N];
        pick_vld = |rot;
        sum      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) sum = (GW+1)'(k);
        end
        sum = sum + {1'b0, rr_q};
        if (sum >= (GW+1)'(N)) sum = sum - (GW+1)'(N);
        pick = sum[GW-1:0];
    end

    // Next-state logic: grant from IDLE, hold the owner until its burst ends.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BURST;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (burst_end) begin
                    state_d = IDLE;
                    rr_d    = rr_next;
                    cnt_d   = '0;
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // One-entry output register; payload only changes when a new beat is taken,
    // so a stalled beat stays stable. A reset drops whatever beat is held.
    always_ff @(posedge aclk) begin
        if (arst) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            src_q    <= '0;
            dst_q    <= '0;
        end else if (load) begin
            tvalid_q <= xfer;
            if (xfer) begin
                tdata_q <= own_data;
                src_q   <= own_src;
                dst_q   <= own_dst;
            end
        end
    end

endmodule

// File: tb/tb_lii_out_arbiter.sv
// Bench for lii_out_arbiter: lane drivers fed from per-lane beat stores,
// expected output beats queued by each test, monitor checks every phy handshake.
module tb_lii_out_arbiter;

    localparam int N  = 4;
    localparam int PW = 32;

    logic            aclk = 1'b0;
    logic            arst = 1'b1;
    logic [N*PW-1:0] req_tdata;
    logic [N-1:0]    req_tvalid, req_tready, req_tlast;
    logic [N*8-1:0]  req_dst;
    logic [PW-1:0]   o_data;
    logic            o_valid;
    logic            phy_rdy = 1'b1;
    logic [7:0]      o_src, o_dst;
    logic [1:0]      grant_id;
    logic            busy;

    always #5 aclk = ~aclk;

    lii_out_arbiter #(.N(N), .PW(PW), .SRC_BASE(16), .MAXBURST(4)) dut (
        .aclk(aclk), .arst(arst),
        .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
        .req_tlast(req_tlast), .req_dst(req_dst),
        .lii_out_p0_tdata(o_data), .lii_out_p0_tvalid(o_valid),
        .lii_out_p0_tready(phy_rdy), .lii_out_p0_src(o_src), .lii_out_p0_dst(o_dst),
        .grant_id(grant_id), .busy(busy)
    );

    // per-lane beat stores
    logic [PW-1:0] sdata [N][32];
    logic          slast [N][32];
    int            wr [N] = '{default: 0};
    int            rd [N] = '{default: 0};
    logic [N-1:0]  hold = '0;
    logic [7:0]    ldst [N] = '{default: 8'h00};
    logic [N-1:0]  hs_drv;

    logic [47:0]   sb [$];
    int            outcyc [$];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            d;

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign req_tvalid[g]          = (rd[g] < wr[g]) && !hold[g];
        assign req_tdata[g*PW +: PW]  = sdata[g][rd[g] % 32];
        assign req_tlast[g]           = slast[g][rd[g] % 32];
        assign req_dst[g*8 +: 8]      = ldst[g];
    end

    always @(posedge aclk) cyc <= cyc + 1;

    // advance a lane's store after each accepted beat
    initial forever begin
        @(negedge aclk);
        hs_drv = arst ? '0 : (req_tvalid & req_tready);
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) if (hs_drv[i]) rd[i] = rd[i] + 1;
    end

    // scoreboard monitor
    initial forever begin
        logic [47:0] e;
        @(negedge aclk);
        if (o_valid && phy_rdy && !arst) begin
            outcyc.push_back(cyc);
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got src=%h dst=%h data=%h, required no beat", o_src, o_dst, o_data);
            end else begin
                e = sb.pop_front();
                if ({o_src, o_dst, o_data} !== e) begin
                    n_fail++;
                    $display("FAIL beat: got src=%h dst=%h data=%h, required src=%h dst=%h data=%h",
                             o_src, o_dst, o_data, e[47:40], e[39:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] mk(int lane, int seq);
        return {8'(lane), 24'(seq)};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, expv);
        end
    endtask

    task automatic push_pkt(int lane, int n, int first);
        for (int b = 0; b < n; b++) begin
            sdata[lane][wr[lane] % 32] = mk(lane, first + b);
            slast[lane][wr[lane] % 32] = (b == n - 1);
            wr[lane] = wr[lane] + 1;
        end
    endtask

    task automatic exp_beats(logic [7:0] src, logic [7:0] dst, int lane, int first, int cnt);
        for (int b = 0; b < cnt; b++) sb.push_back({src, dst, mk(lane, first + b)});
    endtask

    function automatic bit lanes_empty();
        for (int i = 0; i < N; i++) if (rd[i] < wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(string nm);
        int t;
        t = 0;
        while (t < 300 && !(sb.size() == 0 && !o_valid && lanes_empty())) begin
            @(negedge aclk);
            t++;
        end
        n_tests++;
        if (t >= 300) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d beats still expected after %0d cycles, required 0", nm, sb.size(), t);
        end
    endtask

    task automatic do_reset();
        arst    = 1'b1;
        phy_rdy = 1'b1;
        hold    = '0;
        for (int i = 0; i < N; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        sb.delete();
        repeat (2) @(posedge aclk);
        #1 arst = 1'b0;
        outcyc.delete();
    endtask

    initial begin
        // reset state
        do_reset();
        @(negedge aclk);
        chk("rst_tvalid", 64'(o_valid), 64'(0));
        chk("rst_tdata", 64'(o_data), 64'(0));
        chk("rst_src", 64'(o_src), 64'(0));
        chk("rst_dst", 64'(o_dst), 64'(0));
        chk("rst_tready", 64'(req_tready), 64'(0));
        chk("rst_grant", 64'(grant_id), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));

        // 1: single requester, 4-beat packet
        do_reset();
        ldst[2] = 8'h05;
        push_pkt(2, 4, 0);
        exp_beats(8'h12, 8'h05, 2, 0, 4);
        @(negedge aclk);
        chk("t1_busy_pre", 64'(busy), 64'(0));
        @(negedge aclk);
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_grant", 64'(grant_id), 64'(2));
        chk("t1_tready", 64'(req_tready), 64'(4'b0100));
        drain("t1");
        chk("t1_nbeats", 64'(outcyc.size()), 64'(4));
        d = (outcyc.size() >= 4) ? outcyc[3] - outcyc[0] : -1;
        chk("t1_consecutive", 64'(d), 64'(3));
        chk("t1_busy_end", 64'(busy), 64'(0));

        // 2: round-robin fairness, all lanes with two 2-beat packets
        do_reset();
        for (int i = 0; i < N; i++) begin
            ldst[i] = 8'(32 + i);
            push_pkt(i, 2, 0);
            push_pkt(i, 2, 2);
        end
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                exp_beats(8'(16 + i), 8'(32 + i), i, p * 2, 2);
        drain("t2");
        chk("t2_nbeats", 64'(outcyc.size()), 64'(16));
        for (int k = 1; k < 16; k++) begin
            d = (outcyc.size() > k) ? outcyc[k] - outcyc[k-1] : -1;
            chk("t2_gap", 64'(d), 64'(((k % 2) == 1) ? 1 : 2));
        end

        // 3: phy backpressure 1,0,0,1 mid-burst
        do_reset();
        ldst[1] = 8'h07;
        push_pkt(1, 4, 0);
        exp_beats(8'h11, 8'h07, 1, 0, 4);
        repeat (3) @(posedge aclk);
        #1 phy_rdy = 1'b0;
        repeat (2) begin
            @(negedge aclk);
            chk("t3_hold_valid", 64'(o_valid), 64'(1));
            chk("t3_hold_data", 64'(o_data), 64'(mk(1, 1)));
            chk("t3_hold_src", 64'(o_src), 64'(8'h11));
            chk("t3_hold_dst", 64'(o_dst), 64'(8'h07));
            chk("t3_tready_low", 64'(req_tready), 64'(0));
            @(posedge aclk);
        end
        #1 phy_rdy = 1'b1;
        drain("t3");
        chk("t3_nbeats", 64'(outcyc.size()), 64'(4));

        // 4: MAXBURST=4 cut of a 10-beat packet with lane 1 waiting
        do_reset();
        ldst[0] = 8'h30;
        ldst[1] = 8'h31;
        push_pkt(0, 10, 0);
        push_pkt(1, 3, 0);
        exp_beats(8'h10, 8'h30, 0, 0, 4);
        exp_beats(8'h11, 8'h31, 1, 0, 3);
        exp_beats(8'h10, 8'h30, 0, 4, 4);
        exp_beats(8'h10, 8'h30, 0, 8, 2);
        drain("t4");
        chk("t4_nbeats", 64'(outcyc.size()), 64'(13));
        d = (outcyc.size() >= 5) ? outcyc[4] - outcyc[3] : -1;
        chk("t4_cut_gap", 64'(d), 64'(2));

        // 5: owner stalls 5 cycles while lane 3 waits
        do_reset();
        ldst[0] = 8'h40;
        ldst[3] = 8'h43;
        push_pkt(0, 4, 0);
        push_pkt(3, 2, 0);
        exp_beats(8'h10, 8'h40, 0, 0, 4);
        exp_beats(8'h13, 8'h43, 3, 0, 2);
        repeat (3) @(posedge aclk);
        #1 hold[0] = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            chk("t5_grant", 64'(grant_id), 64'(0));
            chk("t5_busy", 64'(busy), 64'(1));
            chk("t5_tready3", 64'(req_tready[3]), 64'(0));
            @(posedge aclk);
        end
        #1 hold[0] = 1'b0;
        drain("t5");

        // 6: reset mid-burst, next grant from lane 0
        do_reset();
        ldst[0] = 8'h50;
        ldst[1] = 8'h51;
        ldst[2] = 8'h52;
        ldst[3] = 8'h53;
        push_pkt(1, 1, 0);
        exp_beats(8'h11, 8'h51, 1, 0, 1);
        drain("t6_pre");
        @(posedge aclk);
        #1 push_pkt(2, 5, 0);
        @(posedge aclk);
        #1;
        push_pkt(0, 2, 0);
        push_pkt(3, 1, 0);
        @(posedge aclk);
        #1 arst = 1'b1;
        @(posedge aclk);
        #1;
        arst  = 1'b0;
        rd[2] = wr[2];
        @(negedge aclk);
        chk("t6_tvalid", 64'(o_valid), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_tready", 64'(req_tready), 64'(0));
        exp_beats(8'h10, 8'h50, 0, 0, 2);
        exp_beats(8'h13, 8'h53, 3, 0, 1);
        @(negedge aclk);
        chk("t6_regrant_busy", 64'(busy), 64'(1));
        chk("t6_regrant_id", 64'(grant_id), 64'(0));
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
